// File: rtl/gps_ack_pkg.sv
// Shared widths, lane record and FSM state for the gps_ack2 peak finder.
// The record struct is what each lane tracker exposes and what the output buffer stores.
package gps_ack_pkg;

    localparam int NUM_CH  = 8;
    localparam int SAT_W   = 6;
    localparam int INT_W   = 16;
    localparam int PHASE_W = 10;
    localparam int DOP_W   = 16;
    localparam int IDX_W   = $clog2(NUM_CH);

    typedef struct packed {
        logic [SAT_W-1:0]          sat;
        logic [INT_W-1:0]          peak;
        logic [PHASE_W-1:0]        phase;
        logic signed [DOP_W-1:0]   dopp;
    } lane_rec_t;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_FINISH  = 2'd2
    } state_t;

endpackage

// File: rtl/gps_ack_lane_peak.sv
// Single-lane max tracker: keeps the largest integrator seen and where it occurred.
// A clear and an update in the same cycle behave as clear-then-update.
import gps_ack_pkg::*;

module gps_ack_lane_peak (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      upd,
    input  logic [SAT_W-1:0]          sat_in,
    input  logic [INT_W-1:0]          integ_in,
    input  logic [PHASE_W-1:0]        phase_in,
    input  logic signed [DOP_W-1:0]   dopp_in,
    output lane_rec_t                 rec
);

    lane_rec_t cur_q;
    lane_rec_t base;

    always_comb begin
        base = cur_q;
        if (clr) begin
            base.peak  = '0;
            base.phase = '0;
            base.dopp  = '0;
        end
    end

    // Strictly greater keeps the first occurrence on ties.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_q <= '0;
        end else begin
            cur_q <= base;
            if (upd) begin
                cur_q.sat <= sat_in;
                if (integ_in > base.peak) begin
                    cur_q.peak  <= integ_in;
                    cur_q.phase <= phase_in;
                    cur_q.dopp  <= dopp_in;
                end
            end
        end
    end

    assign rec = cur_q;

endmodule

// File: rtl/gps_ack_peak_finder.sv
// Per-lane peak tracking downstream of gps_ack2; each satellite block is snapshotted
// and streamed out as NUM_CH detection records.
import gps_ack_pkg::*;

module gps_ack_peak_finder (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       corr_complete,
    input  logic                       sat_block_complete,
    input  logic                       search_complete,
    input  logic [NUM_CH*SAT_W-1:0]    sat_in,
    input  logic [NUM_CH*INT_W-1:0]    integ_in,
    input  logic [PHASE_W-1:0]         code_phase,
    input  logic signed [DOP_W-1:0]    doppler_omega,
    input  logic [INT_W-1:0]           threshold,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [SAT_W-1:0]           res_sat,
    output logic [INT_W-1:0]           res_peak,
    output logic [PHASE_W-1:0]         res_phase,
    output logic signed [DOP_W-1:0]    res_dopp,
    output logic                       res_detect,
    output logic                       res_last,
    output logic                       overrun,
    output logic                       done
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

    logic      corr_q, blk_q, srch_q;
    logic      blk_ev_q, srch_ev_q;
    logic      corr_ev;
    logic      snap;
    state_t    state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic      pend_q, pend_d;
    lane_rec_t lane_rec [NUM_CH];
    lane_rec_t snap_buf [NUM_CH];
    lane_rec_t cur;

    // Correlation edges act immediately; block/search edges are registered so the
    // snapshot lands one cycle later and includes a coincident correlation result.
    assign corr_ev = corr_complete & ~corr_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            corr_q    <= 1'b0;
            blk_q     <= 1'b0;
            srch_q    <= 1'b0;
            blk_ev_q  <= 1'b0;
            srch_ev_q <= 1'b0;
        end else begin
            corr_q    <= corr_complete;
            blk_q     <= sat_block_complete;
            srch_q    <= search_complete;
            blk_ev_q  <= sat_block_complete & ~blk_q;
            srch_ev_q <= search_complete & ~srch_q;
        end
    end

    assign snap = blk_ev_q && (state_q != ST_DRAIN);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        gps_ack_lane_peak u_lane (
            .clk      (clk),
            .rst      (rst),
            .clr      (snap),
            .upd      (corr_ev),
            .sat_in   (sat_in[k*SAT_W +: SAT_W]),
            .integ_in (integ_in[k*INT_W +: INT_W]),
            .phase_in (code_phase),
            .dopp_in  (doppler_omega),
            .rec      (lane_rec[k])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NUM_CH; k++) snap_buf[k] <= '0;
        end else if (snap) begin
            for (int k = 0; k < NUM_CH; k++) snap_buf[k] <= lane_rec[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if (blk_ev_q && state_q == ST_DRAIN) begin
            overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_COLLECT;
            idx_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
        end
    end

    // res_valid/res_ready: a record transfers on a clk edge where both are high;
    // while res_valid is high and res_ready low, every res_* field holds its value.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pend_d    = pend_q;
        res_valid = 1'b0;
        done      = 1'b0;
        cur       = '0;
        case (state_q)
            ST_COLLECT: begin
                if (snap) begin
                    state_d = ST_DRAIN;
                    idx_d   = '0;
                    pend_d  = srch_ev_q;
                end else if (srch_ev_q) begin
                    state_d = ST_FINISH;
                end
            end
            ST_DRAIN: begin
                res_valid = 1'b1;
                cur       = snap_buf[idx_q];
                if (srch_ev_q) pend_d = 1'b1;
                if (res_ready) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        pend_d  = 1'b0;
                        state_d = (pend_q || srch_ev_q) ? ST_FINISH : ST_COLLECT;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_FINISH: begin
                done = 1'b1;
                if (snap) begin
                    state_d = ST_DRAIN;
                    idx_d   = '0;
                    pend_d  = srch_ev_q;
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    assign res_sat    = cur.sat;
    assign res_peak   = cur.peak;
    assign res_phase  = cur.phase;
    assign res_dopp   = cur.dopp;
    assign res_detect = res_valid && (cur.peak >= threshold);
    assign res_last   = (state_q == ST_DRAIN) && (idx_q == IDX_LAST);

endmodule
